// File: rtl/ncpu32k_bpu_bht.sv
// ncpu32k_bpu_bht
//   Dynamic branch predictor for relative jumps. A table of 2-bit saturating
//   counters is indexed by the low word-PC bits, optionally XORed with a
//   global history register (gshare). Lookups are answered one cycle after
//   the strobe. The writeback stage trains the table with resolved outcomes.
//   After reset the table is swept to "weakly not-taken", one entry per cycle.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   bpu_ready           table initialised; lookups and updates are honoured
//   bpu_rd              lookup strobe
//   bpu_insn_pc         word PC of the looked-up instruction
//   bpu_jmprel          looked-up instruction is a relative jump
//   bpu_jmprel_taken    prediction, valid the cycle after bpu_rd
//   bpu_pred_idx        table index behind the prediction, carried down the pipe
//   bpu_wb              writeback strobe
//   bpu_wb_jmprel       written-back instruction is a relative jump
//   bpu_wb_idx          bpu_pred_idx that travelled with that instruction
//   bpu_wb_taken        resolved branch outcome
module ncpu32k_bpu_bht #(
  parameter string BPU_JMPREL_STRATEGY = "bht",
  parameter int    BHT_AW              = 6,
  parameter int    GHR_W               = 0,
  parameter int    NCPU_AW             = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bpu_ready,
  input  logic              bpu_rd,
  input  logic [NCPU_AW-3:0] bpu_insn_pc,
  input  logic              bpu_jmprel,
  output logic              bpu_jmprel_taken,
  output logic [BHT_AW-1:0] bpu_pred_idx,
  input  logic              bpu_wb,
  input  logic              bpu_wb_jmprel,
  input  logic [BHT_AW-1:0] bpu_wb_idx,
  input  logic              bpu_wb_taken
);

  localparam int BHT_N  = 1 << BHT_AW;
  // Keep the history register at least one bit wide so the bimodal
  // configuration still elaborates; its contribution is masked off.
  localparam int GHR_EW = (GHR_W > 0) ? GHR_W : 1;
  localparam bit STRAT_BHT = (BPU_JMPREL_STRATEGY == "bht");
  localparam bit STRAT_AT  = (BPU_JMPREL_STRATEGY == "always_taken");

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [BHT_AW-1:0] cnt_q, cnt_d;
  logic [GHR_EW-1:0] ghr_q, ghr_d;
  logic              taken_q, taken_d;
  logic [BHT_AW-1:0] pred_idx_q, pred_idx_d;

  logic [1:0]        bht_q [BHT_N];

  logic              wr_en;
  logic [BHT_AW-1:0] wr_idx;
  logic [1:0]        wr_data;

  logic [BHT_AW-1:0] ghr_ext;
  logic [BHT_AW-1:0] lk_idx;
  logic              wb_fire;
  logic [1:0]        wb_cur;
  logic [1:0]        wb_new;
  logic              lk_hi;
  logic [GHR_EW:0]   ghr_shift;

  logic              unused_pc_hi;
  assign unused_pc_hi = ^bpu_insn_pc[NCPU_AW-3:BHT_AW];

  assign bpu_ready        = (state_q == S_RUN);
  assign bpu_jmprel_taken = taken_q;
  assign bpu_pred_idx     = pred_idx_q;

  // Lookup index, training arithmetic and the same-cycle bypass. The lookup
  // sees the history as it stood before this cycle's writeback shifts it.
  always_comb begin
    ghr_ext = '0;
    if (GHR_W > 0) ghr_ext = BHT_AW'(ghr_q);
    lk_idx  = bpu_insn_pc[BHT_AW-1:0] ^ ghr_ext;

    wb_fire = bpu_wb & bpu_wb_jmprel & bpu_ready;
    wb_cur  = bht_q[bpu_wb_idx];
    if (bpu_wb_taken) wb_new = (wb_cur == 2'b11) ? 2'b11 : wb_cur + 2'b01;
    else              wb_new = (wb_cur == 2'b00) ? 2'b00 : wb_cur - 2'b01;

    if (wb_fire && (bpu_wb_idx == lk_idx)) lk_hi = wb_new[1];
    else                                   lk_hi = bht_q[lk_idx][1];
  end

  // Init sweep / run FSM and the single table write port. The sweep owns the
  // port during INIT; afterwards only training writes use it. Static
  // strategies never touch the table but still sweep so ready timing matches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = bpu_wb_idx;
    wr_data = wb_new;
    case (state_q)
      S_INIT: begin
        wr_en   = STRAT_BHT;
        wr_idx  = cnt_q;
        wr_data = 2'b01;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        wr_en = STRAT_BHT & wb_fire;
      end
      default: state_d = S_INIT;
    endcase
    if (rst) wr_en = 1'b0;
  end

  // Global history shifts in each resolved relative-jump outcome.
  always_comb begin
    ghr_shift = {ghr_q, bpu_wb_taken};
    ghr_d     = ghr_q;
    if (wb_fire) ghr_d = ghr_shift[GHR_EW-1:0];
  end

  // Prediction outputs only change on an honoured lookup; otherwise they hold.
  always_comb begin
    taken_d    = taken_q;
    pred_idx_d = pred_idx_q;
    if (bpu_rd && bpu_ready) begin
      pred_idx_d = lk_idx;
      if (STRAT_BHT)     taken_d = bpu_jmprel & lk_hi;
      else if (STRAT_AT) taken_d = bpu_jmprel;
      else               taken_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      ghr_q      <= '0;
      taken_q    <= 1'b0;
      pred_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ghr_q      <= ghr_d;
      taken_q    <= taken_d;
      pred_idx_q <= pred_idx_d;
    end
  end

  // Counter storage carries no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (wr_en) bht_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_ncpu32k_bpu_bht.sv
// tb_ncpu32k_bpu_bht
//   Directed bench for the branch predictor. Two instances share stimulus:
//   dut0 is bimodal (GHR_W=0), dut1 uses two history bits. Each driven cycle
//   pushes the expected outputs onto a scoreboard; they are popped and
//   compared just after the following rising edge.
module tb_ncpu32k_bpu_bht;

  logic        clk;
  logic        rst;
  logic        bpu_rd;
  logic [29:0] bpu_insn_pc;
  logic        bpu_jmprel;
  logic        bpu_wb;
  logic        bpu_wb_jmprel;
  logic [5:0]  bpu_wb_idx;
  logic        bpu_wb_taken;

  logic        ready0, taken0;
  logic [5:0]  idx0;
  logic        ready1, taken1;
  logic [5:0]  idx1;

  int compared;
  int mismatched;

  typedef struct {
    string      tag;
    logic       rdy;
    logic       tk;
    logic [5:0] idx;
    logic [5:0] idx1;
  } exp_t;

  exp_t sb[$];

  // Reference state derived from the behavioural description
  logic [1:0] m_bht [64];
  logic [1:0] m_ghr;
  logic       m_taken;
  logic [5:0] m_idx;
  logic [5:0] m_idx1;
  bit         running;
  int         init_left;

  ncpu32k_bpu_bht #(.BHT_AW(6), .GHR_W(0)) dut0 (
    .clk(clk), .rst(rst), .bpu_ready(ready0), .bpu_rd(bpu_rd),
    .bpu_insn_pc(bpu_insn_pc), .bpu_jmprel(bpu_jmprel),
    .bpu_jmprel_taken(taken0), .bpu_pred_idx(idx0), .bpu_wb(bpu_wb),
    .bpu_wb_jmprel(bpu_wb_jmprel), .bpu_wb_idx(bpu_wb_idx),
    .bpu_wb_taken(bpu_wb_taken)
  );

  ncpu32k_bpu_bht #(.BHT_AW(6), .GHR_W(2)) dut1 (
    .clk(clk), .rst(rst), .bpu_ready(ready1), .bpu_rd(bpu_rd),
    .bpu_insn_pc(bpu_insn_pc), .bpu_jmprel(bpu_jmprel),
    .bpu_jmprel_taken(taken1), .bpu_pred_idx(idx1), .bpu_wb(bpu_wb),
    .bpu_wb_jmprel(bpu_wb_jmprel), .bpu_wb_idx(bpu_wb_idx),
    .bpu_wb_taken(bpu_wb_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] satUpd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record what the
  // outputs must be after the next rising edge.
  task automatic applyStimulus(input string tag, input logic r, input logic rd,
                               input logic [29:0] pc, input logic jmp,
                               input logic wb, input logic wbj,
                               input logic [5:0] wi, input logic tk);
    exp_t       e;
    logic [1:0] nv;
    logic [1:0] c;
    logic [5:0] li;
    logic       upd;
    @(negedge clk);
    rst           = r;
    bpu_rd        = rd;
    bpu_insn_pc   = pc;
    bpu_jmprel    = jmp;
    bpu_wb        = wb;
    bpu_wb_jmprel = wbj;
    bpu_wb_idx    = wi;
    bpu_wb_taken  = tk;
    if (r) begin
      init_left = 64;
      running   = 1'b0;
      m_taken   = 1'b0;
      m_idx     = '0;
      m_idx1    = '0;
      m_ghr     = '0;
      foreach (m_bht[i]) m_bht[i] = 2'b01;
    end else if (!running) begin
      init_left--;
      if (init_left == 0) running = 1'b1;
    end else begin
      li  = pc[5:0];
      upd = wb & wbj;
      nv  = satUpd(m_bht[wi], tk);
      if (rd) begin
        c       = (upd && (wi == li)) ? nv : m_bht[li];
        m_taken = jmp & c[1];
        m_idx   = li;
        m_idx1  = li ^ {4'b0000, m_ghr};
      end
      if (upd) begin
        m_bht[wi] = nv;
        m_ghr     = {m_ghr[0], tk};
      end
    end
    e.tag  = tag;
    e.rdy  = running;
    e.tk   = m_taken;
    e.idx  = m_idx;
    e.idx1 = m_idx1;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed=0 entries expected>=1");
      return;
    end
    compared--;
    e = sb.pop_front();
    checkValue({e.tag, "_ready0"}, ready0, e.rdy);
    checkValue({e.tag, "_ready1"}, ready1, e.rdy);
    checkValue({e.tag, "_taken0"}, taken0, e.tk);
    checkValue({e.tag, "_idx0"},   idx0,   e.idx);
    checkValue({e.tag, "_idx1"},   idx1,   e.idx1);
  endtask

  task automatic runCycle(input string tag, input logic r, input logic rd,
                          input logic [29:0] pc, input logic jmp,
                          input logic wb, input logic wbj,
                          input logic [5:0] wi, input logic tk);
    applyStimulus(tag, r, rd, pc, jmp, wb, wbj, wi, tk);
    checkOutput();
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    running       = 1'b0;
    init_left     = 64;
    rst           = 1'b1;
    bpu_rd        = 1'b0;
    bpu_insn_pc   = '0;
    bpu_jmprel    = 1'b0;
    bpu_wb        = 1'b0;
    bpu_wb_jmprel = 1'b0;
    bpu_wb_idx    = '0;
    bpu_wb_taken  = 1'b0;

    // Reset state
    runCycle("rst", 1, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    runCycle("rst", 1, 0, 30'h0, 0, 0, 0, 6'h00, 0);

    // INIT sweep with lookup/training traffic that must be ignored
    for (int i = 0; i < 64; i++) runCycle("T1_init", 0, 1, 30'h10, 1, 1, 1, 6'h10, 1);
    checkValue("T1_ready_at_64", ready0, 1'b1);

    // First lookup sees a weakly not-taken counter
    runCycle("T2_rd", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);
    checkValue("T2_taken", taken0, 1'b0);
    checkValue("T2_idx", idx0, 6'h10);
    runCycle("T2_hold", 0, 0, 30'h3F, 1, 0, 0, 6'h00, 0);

    // Training up to saturation and back one step
    repeat (2) runCycle("T3_wb_t", 0, 0, 30'h0, 0, 1, 1, 6'h10, 1);
    runCycle("T3_rd", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);
    checkValue("T3_taken_strong", taken0, 1'b1);
    repeat (5) runCycle("T3_wb_sat", 0, 0, 30'h0, 0, 1, 1, 6'h10, 1);
    runCycle("T3_wb_nt", 0, 0, 30'h0, 0, 1, 1, 6'h10, 0);
    runCycle("T3_rd2", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);
    checkValue("T3_taken_weak", taken0, 1'b1);
    runCycle("T3_nojmp", 0, 1, 30'h10, 0, 0, 0, 6'h00, 0);
    repeat (3) runCycle("T3_wb_nojmp", 0, 0, 30'h0, 0, 1, 0, 6'h10, 0);
    runCycle("T3_rd3", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);

    // Same-cycle bypass; upper PC bits must not affect the index
    runCycle("T4_bypass", 0, 1, 30'h3FFFFFC5, 1, 1, 1, 6'h05, 1);
    checkValue("T4_taken", taken0, 1'b1);
    checkValue("T4_idx", idx0, 6'h05);

    // Last table entry was initialised too
    runCycle("B_rd3f", 0, 1, 30'h3F, 1, 0, 0, 6'h00, 0);
    runCycle("B_wb3f", 0, 0, 30'h0, 0, 1, 1, 6'h3F, 1);
    runCycle("B_rd3f2", 0, 1, 30'h3F, 1, 0, 0, 6'h00, 0);

    // Lower saturation at 00
    repeat (3) runCycle("B_wb0_nt", 0, 0, 30'h0, 0, 1, 1, 6'h00, 0);
    runCycle("B_wb0_t", 0, 0, 30'h0, 0, 1, 1, 6'h00, 1);
    runCycle("B_rd0", 0, 1, 30'h0, 1, 0, 0, 6'h00, 0);
    checkValue("B_floor_taken", taken0, 1'b0);
    runCycle("B_wb0_t2", 0, 0, 30'h0, 0, 1, 1, 6'h00, 1);
    runCycle("B_rd0b", 0, 1, 30'h0, 1, 0, 0, 6'h00, 0);

    // Global history folded into the index
    repeat (2) runCycle("T5_wb", 0, 0, 30'h0, 0, 1, 1, 6'h20, 1);
    runCycle("T5_rd", 0, 1, 30'h04, 1, 0, 0, 6'h00, 0);
    checkValue("T5_gshare_idx", idx1, 6'h07);
    checkValue("T5_bimodal_idx", idx0, 6'h04);

    // Reset in the middle of INIT restarts the full sweep
    runCycle("T6_rst", 1, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    for (int i = 0; i < 30; i++) runCycle("T6_init_a", 0, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    runCycle("T6_rst_mid", 1, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    for (int i = 0; i < 64; i++) runCycle("T6_init_b", 0, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    runCycle("T6_rd", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);
    repeat (2) runCycle("T6_wb", 0, 0, 30'h0, 0, 1, 1, 6'h10, 1);
    runCycle("T6_rd_trained", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);

    // Reset in RUN wipes trained counters
    runCycle("T6_rst_run", 1, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    checkValue("T6_ready_drop", ready0, 1'b0);
    for (int i = 0; i < 64; i++) runCycle("T6_init_c", 0, 0, 30'h0, 0, 0, 0, 6'h00, 0);
    runCycle("T6_rd_after", 0, 1, 30'h10, 1, 0, 0, 6'h00, 0);
    checkValue("T6_ctr_restored", taken0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
